// File: rtl/gen_lfsr_reg.sv
// Galois LFSR generator feeding a small show-ahead FIFO; the LFSR only advances when a value is pushed.
// Optional macro GEN_LFSR_LOCKUP_FIX_EN: never push an all-zero state and recover it to 1 on the next edge.
module gen_lfsr_reg #(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  TAPS     = WIDTH'(32'h80200003),
    parameter int                DEPTH    = 4,
    parameter logic [WIDTH-1:0]  SEED_RST = WIDTH'(1)
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       en,
    input  logic                       seed_ld,
    input  logic [WIDTH-1:0]           seed,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           q,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       lockup
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             full;
    logic             pop;
    logic             push;
    logic             zero_fix;

    always_comb begin
        next_state = state >> 1;
        if (state[0]) begin
            next_state = (state >> 1) ^ TAPS;
        end
        full = (count == CW'(DEPTH));
        pop  = rd_en & valid & ~seed_ld;
`ifdef GEN_LFSR_LOCKUP_FIX_EN
        zero_fix = (state == '0);
        push     = en & ~seed_ld & (~full | pop) & ~zero_fix;
`else
        zero_fix = 1'b0;
        push     = en & ~seed_ld & (~full | pop);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= SEED_RST;
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else if (seed_ld) begin
            state <= seed;
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            if (zero_fix) begin
                state <= WIDTH'(1);
            end else if (push) begin
                state <= next_state;
            end
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // NOTE: storage is deliberately not reset; valid gates q, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (clr && push) begin
            mem[wptr] <= state;
        end
    end

    assign valid  = (count != '0);
    assign q      = valid ? mem[rptr] : '0;
    assign lockup = (state == '0);

endmodule

// File: tb/tb_gen_lfsr_reg.sv
// Scoreboard bench for gen_lfsr_reg: stimulus queues hand-computed values, a monitor compares on every pop.
module tb_gen_lfsr_reg;

    logic        clk = 1'b0;
    logic        clr;
    logic        en;
    logic        seed_ld;
    logic [31:0] seed;
    logic        rd_en;
    logic [31:0] q;
    logic        valid;
    logic [2:0]  count;
    logic        lockup;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    gen_lfsr_reg dut (
        .clk(clk), .clr(clr), .en(en), .seed_ld(seed_ld), .seed(seed),
        .rd_en(rd_en), .q(q), .valid(valid), .count(count), .lockup(lockup)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    // Monitor: a pop happens just before the coming edge whenever rd_en meets valid.
    always @(negedge clk) begin
        if (clr && !seed_ld && rd_en && valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected none", q);
            end else begin
                check("pop_q", q, exp_q.pop_front());
            end
        end
    end

    initial begin
        clr = 1'b0; en = 1'b0; seed_ld = 1'b0; seed = '0; rd_en = 1'b0;
        cyc(2);
        check("rst_count", count, 0);
        check("rst_valid", valid, 0);
        check("rst_q", q, 0);
        check("rst_lockup", lockup, 0);
        clr = 1'b1;

        // Fill from reset seed, then confirm the LFSR freezes while full.
        en = 1'b1;
        expect_push(32'h00000001);
        expect_push(32'h80200003);
        expect_push(32'hC0300002);
        expect_push(32'h60180001);
        cyc(4);
        check("fill_count", count, 4);
        check("fill_head", q, 32'h00000001);
        cyc(2);
        check("frozen_count", count, 4);

        // Full with simultaneous pop/push: the frozen state continues the sequence.
        rd_en = 1'b1;
        expect_push(32'hB02C0003);
        expect_push(32'hD8360002);
        expect_push(32'h6C1B0001);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("pushpop_count", count, 4);
        end
        en = 1'b0;
        cyc(4);
        check("drain_count", count, 0);
        check("drain_valid", valid, 0);

        // Reads on an empty buffer are ignored.
        cyc(2);
        check("empty_rd_count", count, 0);
        check("empty_rd_q", q, 0);

        // Partial fill, then reseed while reading.
        rd_en = 1'b0; en = 1'b1;
        expect_push(32'hB62D8003);
        expect_push(32'hDB36C002);
        expect_push(32'h6D9B6001);
        cyc(3);
        check("partial_count", count, 3);
        check("empty_rd_head", q, 32'hB62D8003);
        seed_ld = 1'b1; seed = 32'h12345678; rd_en = 1'b1;
        cyc(1);
        exp_q.delete();
        seed_ld = 1'b0; rd_en = 1'b0;
        check("seed_count", count, 0);
        check("seed_valid", valid, 0);
        check("seed_q", q, 0);
        expect_push(32'h12345678);
        expect_push(32'h091A2B3C);
        cyc(2);
        en = 1'b0; rd_en = 1'b1;
        cyc(2);
        check("seed_drain_count", count, 0);

        // Reset mid-fill restarts from the reset seed.
        rd_en = 1'b0; en = 1'b1;
        expect_push(32'h048D159E);
        expect_push(32'h02468ACF);
        cyc(2);
        check("midfill_count", count, 2);
        clr = 1'b0;
        cyc(1);
        exp_q.delete();
        clr = 1'b1;
        check("clr_count", count, 0);
        check("clr_valid", valid, 0);
        expect_push(32'h00000001);
        cyc(1);
        en = 1'b0; rd_en = 1'b1;
        cyc(1);
        check("clr_drain_count", count, 0);

        // Zero seed: lockup handling depends on the build option.
        rd_en = 1'b0; en = 1'b1; seed_ld = 1'b1; seed = '0;
        cyc(1);
        seed_ld = 1'b0;
        check("zero_lockup", lockup, 1);
`ifdef GEN_LFSR_LOCKUP_FIX_EN
        cyc(1);
        check("fix_lockup_clear", lockup, 0);
        check("fix_no_zero_push", count, 0);
        expect_push(32'h00000001);
        cyc(1);
        check("fix_push_count", count, 1);
`else
        expect_push(32'h00000000);
        expect_push(32'h00000000);
        cyc(2);
        check("nofix_lockup_held", lockup, 1);
        check("nofix_push_count", count, 2);
`endif
        en = 1'b0; rd_en = 1'b1;
        cyc(3);
        check("final_count", count, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
